// File: rtl/receptor_mdio.sv
// Clause-22 MDIO target: oversamples mdc in the clk domain, decodes frames,
// strobes writes to a local register file and serialises read data back.
//
// state   | meaning
// IDLE    | waiting for ST[1]=0 with controller driving (preamble ones ignored)
// HDR     | shifting bits 1..13 (ST[0], OP, PHYAD, REGAD)
// WR_TA   | write turnaround, expect 1 then 0
// WR_DATA | shifting write data bits 16..31
// RD_TA   | read turnaround, bit 14 released, target drives 0 for bit 15
// RD_DATA | shifting read data out on mdc falls
// DISCARD | counting out a frame not for us (or malformed) to bit 31
module receptor_mdio #(
    parameter logic [4:0] PHY_ADDR = 5'h01
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mdc,
    input  logic        mdio_oe,
    input  logic        mdio_out,
    input  logic [15:0] rd_data,
    output logic        mdio_in,
    output logic        mdio_in_oe,
    output logic [4:0]  reg_addr,
    output logic [15:0] wr_data,
    output logic        wr_stb,
    output logic        rd_stb,
    output logic        frame_err
);

    typedef enum logic [2:0] {
        IDLE, HDR, WR_TA, WR_DATA, RD_TA, RD_DATA, DISCARD
    } state_t;

    state_t      state, state_nx;
    logic        mdc_q;
    logic        rise, fall;
    logic [4:0]  bc, bc_nx;
    logic [10:0] hdr;
    logic [11:0] hdr_full;
    logic [14:0] wr_sh;
    logic [15:0] tx;

    logic err_nx, wr_nx, rd_nx, addr_ld, hdr_ld, wsh_ld;
    logic drv_ta, drv_bit, drv_end;

    assign rise     = mdc & ~mdc_q;
    assign fall     = ~mdc & mdc_q;
    // {OP, PHYAD, REGAD} as seen at the rise of bit 13
    assign hdr_full = {hdr, mdio_out};

    always_comb begin
        state_nx = state;
        bc_nx    = bc;
        err_nx   = 1'b0;
        wr_nx    = 1'b0;
        rd_nx    = 1'b0;
        addr_ld  = 1'b0;
        hdr_ld   = 1'b0;
        wsh_ld   = 1'b0;
        drv_ta   = 1'b0;
        drv_bit  = 1'b0;
        drv_end  = 1'b0;
        case (state)
            IDLE: begin
                if (rise && mdio_oe && !mdio_out) begin
                    bc_nx    = 5'd1;
                    state_nx = HDR;
                end
            end
            HDR: begin
                if (rise) begin
                    if (!mdio_oe || (bc == 5'd1 && !mdio_out)) begin
                        err_nx   = 1'b1;
                        bc_nx    = 5'd0;
                        state_nx = IDLE;
                    end else begin
                        bc_nx = bc + 5'd1;
                        if (bc != 5'd1)
                            hdr_ld = 1'b1;
                        if (bc == 5'd13) begin
                            if (hdr_full[9:5] != PHY_ADDR) begin
                                state_nx = DISCARD;
                            end else if (hdr_full[11:10] == 2'b01) begin
                                addr_ld  = 1'b1;
                                state_nx = WR_TA;
                            end else if (hdr_full[11:10] == 2'b10) begin
                                addr_ld  = 1'b1;
                                rd_nx    = 1'b1;
                                state_nx = RD_TA;
                            end else begin
                                err_nx   = 1'b1;
                                state_nx = DISCARD;
                            end
                        end
                    end
                end
            end
            WR_TA: begin
                if (rise) begin
                    bc_nx = bc + 5'd1;
                    if (!mdio_oe || (mdio_out != (bc == 5'd14))) begin
                        err_nx   = 1'b1;
                        state_nx = DISCARD;
                    end else if (bc == 5'd15) begin
                        state_nx = WR_DATA;
                    end
                end
            end
            WR_DATA: begin
                if (rise) begin
                    if (!mdio_oe) begin
                        err_nx   = 1'b1;
                        bc_nx    = 5'd0;
                        state_nx = IDLE;
                    end else begin
                        wsh_ld = 1'b1;
                        bc_nx  = bc + 5'd1;
                        if (bc == 5'd31) begin
                            wr_nx    = 1'b1;
                            state_nx = IDLE;
                        end
                    end
                end
            end
            RD_TA: begin
                if (rise) begin
                    bc_nx = bc + 5'd1;
                    if (bc == 5'd15)
                        state_nx = RD_DATA;
                end else if (fall && bc == 5'd15) begin
                    drv_ta = 1'b1;
                end
            end
            RD_DATA: begin
                // bc wraps to 0 after the bit-31 rise, marking the final fall
                if (rise) begin
                    bc_nx = bc + 5'd1;
                end else if (fall) begin
                    if (bc == 5'd0) begin
                        drv_end  = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        drv_bit = 1'b1;
                    end
                end
            end
            DISCARD: begin
                if (rise) begin
                    bc_nx = bc + 5'd1;
                    if (bc == 5'd31)
                        state_nx = IDLE;
                end
            end
            default: begin
                bc_nx    = 5'd0;
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            mdc_q      <= 1'b0;
            bc         <= 5'd0;
            hdr        <= '0;
            wr_sh      <= '0;
            tx         <= '0;
            mdio_in    <= 1'b0;
            mdio_in_oe <= 1'b0;
            reg_addr   <= '0;
            wr_data    <= '0;
            wr_stb     <= 1'b0;
            rd_stb     <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            mdc_q     <= mdc;
            state     <= state_nx;
            bc        <= bc_nx;
            frame_err <= err_nx;
            wr_stb    <= wr_nx;
            rd_stb    <= rd_nx;
            if (hdr_ld)
                hdr <= hdr_full[10:0];
            if (addr_ld)
                reg_addr <= hdr_full[4:0];
            if (wsh_ld)
                wr_sh <= {wr_sh[13:0], mdio_out};
            if (wr_nx)
                wr_data <= {wr_sh, mdio_out};
            if (rd_stb)
                tx <= rd_data;
            else if (drv_bit)
                tx <= {tx[14:0], 1'b0};
            if (drv_ta) begin
                mdio_in_oe <= 1'b1;
                mdio_in    <= 1'b0;
            end
            if (drv_bit)
                mdio_in <= tx[15];
            if (drv_end) begin
                mdio_in_oe <= 1'b0;
                mdio_in    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_receptor_mdio.sv
// Scoreboarded bench for receptor_mdio: directed Clause-22 frames plus
// random frames checked against a register-file model.
module tb_receptor_mdio;

    localparam int         H   = 4;
    localparam logic [4:0] PHY = 5'h01;
    localparam int K_WR = 0, K_RD = 1, K_ERR = 2, K_RDD = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        mdc;
    logic        mdio_oe;
    logic        mdio_out;
    logic [15:0] rd_data;
    logic        mdio_in;
    logic        mdio_in_oe;
    logic [4:0]  reg_addr;
    logic [15:0] wr_data;
    logic        wr_stb;
    logic        rd_stb;
    logic        frame_err;

    always #5 clk = ~clk;

    receptor_mdio #(.PHY_ADDR(PHY)) dut (
        .clk       (clk),
        .reset     (reset),
        .mdc       (mdc),
        .mdio_oe   (mdio_oe),
        .mdio_out  (mdio_out),
        .rd_data   (rd_data),
        .mdio_in   (mdio_in),
        .mdio_in_oe(mdio_in_oe),
        .reg_addr  (reg_addr),
        .wr_data   (wr_data),
        .wr_stb    (wr_stb),
        .rd_stb    (rd_stb),
        .frame_err (frame_err)
    );

    typedef struct {
        int         kind;
        logic [4:0] addr;
        logic [15:0] data;
    } ev_t;

    ev_t         exp_q[$];
    logic [15:0] regs [32];
    logic [4:0]  last_addr;
    logic [15:0] last_wr;
    int          checks   = 0;
    int          failures = 0;

    // register file model answering the target's current address
    assign rd_data = regs[reg_addr];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic push(input int k, input logic [4:0] a, input logic [15:0] d);
        ev_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic mdc_cycle(input logic oe, input logic d);
        @(negedge clk);
        mdio_oe  = oe;
        mdio_out = d;
        repeat (H) @(negedge clk);
        mdc = 1'b1;
        repeat (H) @(negedge clk);
        mdc = 1'b0;
    endtask

    task automatic send_frame(input logic [1:0] op, input logic [4:0] phy, input logic [4:0] ra,
                              input logic [1:0] ta, input logic [15:0] d, input int pre,
                              input int stop_after);
        logic [31:0] f;
        bit rel;
        f   = {2'b01, op, phy, ra, ta, d};
        rel = (op == 2'b10);
        for (int i = 0; i < pre; i++)
            mdc_cycle(1'b1, 1'b1);
        for (int i = 0; i < 32; i++) begin
            if (rel && i >= 14)
                mdc_cycle(1'b0, 1'b0);
            else
                mdc_cycle(1'b1, f[31-i]);
            if (i == stop_after)
                return;
        end
        @(negedge clk);
        mdio_oe  = 1'b0;
        mdio_out = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // expected outcome from the frame rules, then drive it and check held outputs
    task automatic issue(input logic [1:0] op, input logic [4:0] phy, input logic [4:0] ra,
                         input logic [1:0] ta, input logic [15:0] d, input int pre);
        if (phy == PHY) begin
            if (op == 2'b01) begin
                last_addr = ra;
                if (ta == 2'b10) begin
                    push(K_WR, ra, d);
                    regs[ra] = d;
                    last_wr  = d;
                end else begin
                    push(K_ERR, 5'd0, 16'd0);
                end
            end else if (op == 2'b10) begin
                last_addr = ra;
                push(K_RD, ra, 16'd0);
                push(K_RDD, ra, regs[ra]);
            end else begin
                push(K_ERR, 5'd0, 16'd0);
            end
        end
        send_frame(op, phy, ra, ta, d, pre, -1);
        check("reg_addr_hold", {27'd0, reg_addr}, {27'd0, last_addr});
        check("wr_data_hold", {16'd0, wr_data}, {16'd0, last_wr});
    endtask

    // monitor: pops the scoreboard whenever the DUT presents a strobe or a read word
    ev_t         me;
    logic        prev_mdc = 1'b0;
    logic        prev_oe  = 1'b0;
    int          nbits    = 0;
    logic [16:0] sh       = '0;
    bit          coll     = 1'b0;
    int          obs;

    always begin
        @(posedge clk);
        #3;
        if (!reset) begin
            coll     = 1'b0;
            nbits    = 0;
            sh       = '0;
            prev_mdc = 1'b0;
            prev_oe  = 1'b0;
        end else begin
            if (wr_stb || rd_stb || frame_err) begin
                check("strobe_excl", 32'(wr_stb) + 32'(rd_stb) + 32'(frame_err), 32'd1);
                obs = wr_stb ? K_WR : (rd_stb ? K_RD : K_ERR);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_event got_kind=%0d expected=none t=%0t", obs, $time);
                end else begin
                    me = exp_q.pop_front();
                    check("event_kind", obs, me.kind);
                    if (obs == K_WR) begin
                        check("wr_addr", {27'd0, reg_addr}, {27'd0, me.addr});
                        check("wr_data", {16'd0, wr_data}, {16'd0, me.data});
                    end else if (obs == K_RD) begin
                        check("rd_addr", {27'd0, reg_addr}, {27'd0, me.addr});
                    end
                end
            end
            if (mdc && !prev_mdc) begin
                if (mdio_in_oe) begin
                    sh    = {sh[15:0], mdio_in};
                    nbits = nbits + 1;
                    coll  = 1'b1;
                end else begin
                    check("mdio_in_idle_zero", {31'd0, mdio_in}, 32'd0);
                end
            end
            if (prev_oe && !mdio_in_oe && coll) begin
                check("rd_bit_count", nbits, 17);
                check("rd_ta_zero", {31'd0, sh[16]}, 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_read_word got=%0h expected=none", sh[15:0]);
                end else begin
                    me = exp_q.pop_front();
                    check("rdd_kind", K_RDD, me.kind);
                    check("rd_word", {16'd0, sh[15:0]}, {16'd0, me.data});
                end
                coll  = 1'b0;
                nbits = 0;
                sh    = '0;
            end
            prev_mdc = mdc;
            prev_oe  = mdio_in_oe;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog_timeout got=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  op, ta;
        logic [4:0]  phy, ra;
        logic [15:0] d;
        int          kind;

        for (int i = 0; i < 32; i++)
            regs[i] = 16'($urandom);
        regs[3]   = 16'h1234;
        reset     = 1'b0;
        mdc       = 1'b0;
        mdio_oe   = 1'b0;
        mdio_out  = 1'b0;
        last_addr = 5'd0;
        last_wr   = 16'd0;
        repeat (3) @(negedge clk);
        check("rst_mdio_in", {31'd0, mdio_in}, 32'd0);
        check("rst_mdio_in_oe", {31'd0, mdio_in_oe}, 32'd0);
        check("rst_reg_addr", {27'd0, reg_addr}, 32'd0);
        check("rst_wr_data", {16'd0, wr_data}, 32'd0);
        check("rst_strobes", {29'd0, wr_stb, rd_stb, frame_err}, 32'd0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        issue(2'b01, PHY, 5'h05, 2'b10, 16'hABCD, 32);
        issue(2'b10, PHY, 5'h03, 2'b00, 16'h0000, 4);
        issue(2'b01, 5'h07, 5'h0A, 2'b10, 16'h5555, 2);
        issue(2'b01, PHY, 5'h0A, 2'b10, 16'h6789, 2);
        issue(2'b11, PHY, 5'h02, 2'b10, 16'hFFFF, 1);
        issue(2'b01, PHY, 5'h04, 2'b00, 16'h0F0F, 3);

        // read aborted by reset while the target is driving
        push(K_RD, 5'h09, 16'd0);
        send_frame(2'b10, PHY, 5'h09, 2'b00, 16'h0000, 2, 20);
        check("pre_abort_oe", {31'd0, mdio_in_oe}, 32'd1);
        reset = 1'b0;
        #1;
        check("abort_oe", {31'd0, mdio_in_oe}, 32'd0);
        check("abort_in", {31'd0, mdio_in}, 32'd0);
        check("abort_strobes", {29'd0, wr_stb, rd_stb, frame_err}, 32'd0);
        mdc       = 1'b0;
        mdio_oe   = 1'b0;
        mdio_out  = 1'b0;
        last_addr = 5'd0;
        last_wr   = 16'd0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        issue(2'b10, PHY, 5'h03, 2'b00, 16'h0000, 1);

        for (int n = 0; n < 40; n++) begin
            kind = int'($urandom_range(0, 4));
            ra   = 5'($urandom);
            d    = 16'($urandom);
            phy  = PHY;
            ta   = 2'b10;
            op   = 2'b01;
            case (kind)
                1: op = 2'b10;
                2: begin
                    op = 2'($urandom);
                    do phy = 5'($urandom); while (phy == PHY);
                end
                3: op = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
                4: begin
                    do ta = 2'($urandom); while (ta == 2'b10);
                end
                default: op = 2'b01;
            endcase
            issue(op, phy, ra, ta, d, int'($urandom_range(0, 8)));
        end

        repeat (20) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/receptor_mdio.md
Name: receptor_mdio

Overview:
- MDIO target (PHY-side management responder) at the far end of the team's MDIO controller.
- Samples the controller's MDC/MDIO_OUT in the system clock domain and decodes Clause-22 frames: ST(2) OP(2) PHYAD(5) REGAD(5) TA(2) DATA(16), 32 bits, MSB first.
- Write frames: presents address and data to a local register file with a one-cycle strobe.
- Read frames: fetches register data and drives it back serially on mdio_in.

Parameters:
- PHY_ADDR, 5'h01, PHY address this target answers; frames with another PHYAD are silently discarded.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-low reset.
- mdc  input  1  management clock from controller; sampled by clk, never used as a clock.
- mdio_oe  input  1  controller output enable; high = controller is driving mdio_out.
- mdio_out  input  1  serial data from controller.
- rd_data  input  16  register contents for reg_addr; sampled when rd_stb is high.
- mdio_in  output  1  serial read data to controller.
- mdio_in_oe  output  1  target drives mdio_in.
- reg_addr  output  5  REGAD of the current/last accepted frame.
- wr_data  output  16  data of the last completed write.
- wr_stb  output  1  one-clk pulse: wr_data/reg_addr valid for a write.
- rd_stb  output  1  one-clk pulse: rd_data sampled.
- frame_err  output  1  one-clk pulse on a malformed frame.

Behaviour:
- Reset low: all outputs 0, state IDLE, bit counter 0, internal mdc_q 0, shift registers 0; reset asserted mid-frame aborts the frame with no strobe.
- Edge detect: mdc_q <= mdc each clk; rise = mdc & ~mdc_q; fall = ~mdc & mdc_q. All bit sampling happens on a rise, all target driving changes on a fall.
- Bit counter bc (5 bits) counts sampled bits 0..31 within a frame.
- IDLE: on a rise with mdio_oe=1 and mdio_out=0, capture ST[1], bc=1, go HDR. Other rises are ignored, which absorbs preamble ones.
- HDR (bits 1..13): shift mdio_out into hdr on each rise. Bit 1 must be 1 (ST=01); otherwise frame_err and go IDLE. A rise with mdio_oe=0 also gives frame_err and IDLE.
- Decode at the rise of bit 13:
  - OP=01 and PHYAD match: reg_addr <= REGAD, go WR_TA.
  - OP=10 and PHYAD match: reg_addr <= REGAD, rd_stb pulses the next clk, rd_data is captured into the tx shifter the clk after that, go RD_TA.
  - PHYAD mismatch: go DISCARD, no error.
  - OP 00 or 11: frame_err, go DISCARD.
- WR_TA (bits 14,15): expect 1 then 0 from the controller; any mismatch gives frame_err and DISCARD.
- WR_DATA (bits 16..31): shift in MSB first.
  - At the rise of bit 31: wr_data <= 16 shifted bits, wr_stb pulses the following clk, go IDLE.
  - mdio_oe=0 on any rise gives frame_err and IDLE.
- RD_TA:
  - Bit 14 is released by both sides (mdio_in_oe=0).
  - On the fall after the bit-14 rise: mdio_in_oe<=1, mdio_in<=0 (second TA bit).
  - On the fall after the bit-15 rise: mdio_in<=tx[15].
- RD_DATA:
  - Each fall after the rise of bits 16..30 shifts out the next bit, so tx[15-k] is valid for the bit-(16+k) rise.
  - On the fall after the bit-31 rise: mdio_in_oe<=0, mdio_in<=0, go IDLE.
  - mdio_oe is ignored here.
- DISCARD: count rises to bit 31, drive nothing, return to IDLE.
- Strobes never assert together. reg_addr and wr_data hold their values until the next accepted frame.
- mdio_in is 0 whenever mdio_in_oe is 0.

Test Plan:
- Reset low mid-read (mdio_in_oe=1) -> mdio_in_oe, mdio_in, all strobes 0 immediately; next valid frame decodes normally.
- Write frame 01_01_00001_00101_10_ABCD with PHY_ADDR=1, 32 preamble ones first -> single wr_stb, reg_addr=5'h05, wr_data=16'hABCD, frame_err never pulses.
- Read frame 01_10_00001_00011, rd_data=16'h1234 -> one rd_stb; mdio_in_oe rises after the bit-14 rise; controller samples 0 at bit 15 and 0001_0010_0011_0100 at bits 16..31; oe low after bit 31.
- Write to PHYAD 5'h07 with PHY_ADDR=1 -> no wr_stb, no frame_err, mdio_in_oe stays 0; a following valid write to addr 1 is accepted.
- OP=11 frame -> frame_err pulse once; remainder discarded; IDLE after bit 31.
- Write frame with TA sent as 0,0 -> frame_err, no wr_stb, wr_data keeps its prior value.
